// File: rtl/reg_xfer_seq.sv
// reg_xfer_seq: sequences 8085 MOV/MVI data moves between the register file and memory.
// Optional macro XFER_TIMEOUT_EN aborts a memory wait after TIMEOUT_CYCLES cycles.
module reg_xfer_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op_src,
  input  logic [2:0] op_dst,
  input  logic       op_imm_en,
  input  logic [7:0] op_imm,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       rf_en,
  output logic       rf_en_read,
  output logic [2:0] rf_addr,
  inout  wire  [7:0] data_bus,
  output logic       mem_rd,
  output logic       mem_wr,
  input  logic       mem_ready
);

  localparam int unsigned CODE_W = 3;
  localparam int unsigned DATA_W = 8;
  localparam logic [CODE_W-1:0] CODE_NONE = CODE_W'(0);
  localparam logic [CODE_W-1:0] CODE_M    = CODE_W'(7);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SRC_RD = 3'd1,
    MEM_RD = 3'd2,
    DST_WR = 3'd3,
    MEM_WR = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  state_t              state, state_d;
  logic [CODE_W-1:0]   src_q, src_d;
  logic [CODE_W-1:0]   dst_q, dst_d;
  logic [DATA_W-1:0]   temp, temp_d;
  logic                bus_oe;
  logic                busy_d, done_d, err_d;
  logic                rf_en_d, rf_en_read_d, mem_rd_d, mem_wr_d, bus_oe_d;
  logic [CODE_W-1:0]   rf_addr_d;
  logic                illegal;
  logic                wait_expired;

  // The bus carries temp only while writing a register or memory.
  assign data_bus = bus_oe ? temp : {DATA_W{1'bz}};

  assign illegal = (op_dst == CODE_NONE) ||
                   (!op_imm_en && ((op_src == CODE_NONE) ||
                                   ((op_src == CODE_M) && (op_dst == CODE_M))));

`ifdef XFER_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 15;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;

  assign waiting = (state == MEM_RD) || (state == MEM_WR);

  // Wait counter is zero whenever not in a memory state, so it starts clean on entry.
  always_ff @(posedge clk) begin
    if (reset || !waiting) begin
      wait_cnt <= '0;
    end else if (!mem_ready) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign wait_expired = waiting && !mem_ready &&
                        (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign wait_expired = 1'b0;
`endif

  // State, operand and registered output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      temp       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rf_en      <= 1'b0;
      rf_en_read <= 1'b0;
      rf_addr    <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      bus_oe     <= 1'b0;
    end else begin
      state      <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      temp       <= temp_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      rf_en      <= rf_en_d;
      rf_en_read <= rf_en_read_d;
      rf_addr    <= rf_addr_d;
      mem_rd     <= mem_rd_d;
      mem_wr     <= mem_wr_d;
      bus_oe     <= bus_oe_d;
    end
  end

  // Next state, then outputs decoded from the next state so they register alongside it.
  always_comb begin
    state_d      = state;
    src_d        = src_q;
    dst_d        = dst_q;
    temp_d       = temp;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    rf_en_d      = 1'b0;
    rf_en_read_d = 1'b0;
    rf_addr_d    = '0;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    bus_oe_d     = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          src_d = op_src;
          dst_d = op_dst;
          if (illegal) begin
            state_d = ERR;
          end else if (op_imm_en) begin
            temp_d  = op_imm;
            state_d = (op_dst == CODE_M) ? MEM_WR : DST_WR;
          end else begin
            state_d = (op_src == CODE_M) ? MEM_RD : SRC_RD;
          end
        end
      end
      SRC_RD: begin
        temp_d  = data_bus;
        state_d = (dst_q == CODE_M) ? MEM_WR : DST_WR;
      end
      MEM_RD: begin
        if (mem_ready) begin
          temp_d  = data_bus;
          state_d = DST_WR;
        end else if (wait_expired) begin
          state_d = ERR;
        end
      end
      DST_WR: state_d = DONE;
      MEM_WR: begin
        if (mem_ready) begin
          state_d = DONE;
        end else if (wait_expired) begin
          state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    unique case (state_d)
      SRC_RD: begin
        rf_en_d   = 1'b1;
        rf_addr_d = src_d;
      end
      MEM_RD: begin
        rf_en_d   = 1'b1;
        rf_addr_d = CODE_M;
        mem_rd_d  = 1'b1;
      end
      DST_WR: begin
        rf_en_read_d = 1'b1;
        rf_addr_d    = dst_d;
        bus_oe_d     = 1'b1;
      end
      MEM_WR: begin
        rf_en_d   = 1'b1;
        rf_addr_d = CODE_M;
        mem_wr_d  = 1'b1;
        bus_oe_d  = 1'b1;
      end
      DONE:    done_d = 1'b1;
      ERR:     err_d  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_xfer_seq.sv
// tb_reg_xfer_seq: register file + memory environment around reg_xfer_seq with
// directed vectors, corner sequences and randomized ops against a move-level model.
module tb_reg_xfer_seq;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic       rf_en;
    logic       rf_en_read;
    logic [2:0] rf_addr;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] bus;
  } snap_t;

  typedef struct {
    bit         imm_en;
    logic [2:0] src;
    logic [2:0] dst;
    logic [7:0] imm;
    int         wt;
    bit         exp_err;
    int         exp_lat;
    logic [7:0] exp_val;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, start, op_imm_en, mem_ready;
  logic [2:0] op_src, op_dst;
  logic [7:0] op_imm;
  logic       busy, done, err, rf_en, rf_en_read, mem_rd, mem_wr;
  logic [2:0] rf_addr;
  wire  [7:0] data_bus;

  logic [7:0] rf  [0:7];
  logic [7:0] mrf [0:7];
  logic [7:0] mem [0:65535];
  logic [15:0] hl;
  logic       probe_en;
  logic [7:0] probe_val;

  int total = 0;
  int bad   = 0;

  snap_t tr [0:47];
  int    op_lat, n_rd, n_wr;
  bit    op_done, op_err, op_viol, op_act, op_busy_after;

  always #5 clk = ~clk;

  assign hl = {rf[5], rf[6]};
  assign data_bus = (rf_en && rf_addr != 3'd0 && rf_addr != 3'd7) ? rf[rf_addr] :
                    mem_rd   ? mem[hl] :
                    probe_en ? probe_val : 8'hzz;

  reg_xfer_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .op_src(op_src), .op_dst(op_dst), .op_imm_en(op_imm_en), .op_imm(op_imm),
    .busy(busy), .done(done), .err(err),
    .rf_en(rf_en), .rf_en_read(rf_en_read), .rf_addr(rf_addr),
    .data_bus(data_bus), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ready(mem_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launch one op and run it to done/err, acting as register file and memory.
  task automatic do_op(input bit imm_en, input logic [2:0] src, input logic [2:0] dst,
                       input logic [7:0] imm, input int wt, input bit noisy);
    int wcnt = 0;
    bit fin = 0;
    op_lat = -1; op_done = 0; op_err = 0; op_viol = 0; op_act = 0;
    op_busy_after = 1; n_rd = 0; n_wr = 0;
    op_imm_en = imm_en; op_src = src; op_dst = dst; op_imm = imm;
    start = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    for (int c = 1; c <= 40 && !fin; c++) begin
      tr[c] = {busy, done, err, rf_en, rf_en_read, rf_addr, mem_rd, mem_wr, data_bus};
      if (rf_en && rf_en_read) op_viol = 1;
      if (rf_en_read && (rf_addr == 3'd0 || rf_addr == 3'd7)) op_viol = 1;
      if (rf_en || rf_en_read || mem_rd || mem_wr) op_act = 1;
      if (mem_rd) n_rd++;
      if (mem_wr) n_wr++;
      if (done || err) begin
        op_done = done; op_err = err; op_lat = c; fin = 1;
        start = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        tr[c+1] = {busy, done, err, rf_en, rf_en_read, rf_addr, mem_rd, mem_wr, data_bus};
        op_busy_after = busy;
      end else begin
        if (mem_rd || mem_wr) begin
          mem_ready = (wcnt >= wt);
          wcnt++;
        end else begin
          mem_ready = noisy ? 1'($urandom) : 1'b0;
        end
        start = noisy ? 1'($urandom) : 1'b0;
        if (noisy) begin
          op_imm_en = 1'($urandom); op_src = 3'($urandom);
          op_dst = 3'($urandom); op_imm = 8'($urandom);
        end
        if (rf_en_read) rf[rf_addr] = data_bus;
        if (mem_wr && mem_ready) mem[hl] = data_bus;
        @(posedge clk); #1;
      end
    end
    start = 1'b0; mem_ready = 1'b0;
  endtask

  // Model: decide legality, moved value and latency from the move rules, then compare.
  task automatic run_vec(input vec_t v, input bit noisy, input bit use_exp, input string tag);
    bit legal;
    logic [15:0] hl0;
    logic [7:0] val, got;
    int lat_m;
    legal = (v.dst != 3'd0) &&
            (v.imm_en || (v.src != 3'd0 && !(v.src == 3'd7 && v.dst == 3'd7)));
    hl0 = {mrf[5], mrf[6]};
    val = v.imm_en ? v.imm : (v.src == 3'd7 ? mem[hl0] : mrf[v.src]);
    if (!legal) lat_m = 1;
    else lat_m = (v.imm_en ? 2 : 3) + (((!v.imm_en && v.src == 3'd7) || v.dst == 3'd7) ? v.wt : 0);
    do_op(v.imm_en, v.src, v.dst, v.imm, v.wt, noisy);
    if (legal && v.dst != 3'd7) mrf[v.dst] = val;
    chk({tag, "_latency"}, 64'(op_lat), 64'(lat_m));
    chk({tag, "_done"}, 64'(op_done), 64'(legal));
    chk({tag, "_err"}, 64'(op_err), 64'(!legal));
    if (!legal) chk({tag, "_err_activity"}, 64'(op_act), 64'd0);
    chk({tag, "_rf_strobe_rules"}, 64'(op_viol), 64'd0);
    chk({tag, "_busy_after"}, 64'(op_busy_after), 64'd0);
    chk({tag, "_regs"}, {rf[1], rf[2], rf[3], rf[4], rf[5], rf[6]},
                        {mrf[1], mrf[2], mrf[3], mrf[4], mrf[5], mrf[6]});
    if (legal && v.dst == 3'd7) chk({tag, "_mem"}, 64'(mem[hl0]), 64'(val));
    if (use_exp) begin
      chk({tag, "_tbl_latency"}, 64'(op_lat), 64'(v.exp_lat));
      chk({tag, "_tbl_err"}, 64'(op_err), 64'(v.exp_err));
      if (!v.exp_err) begin
        got = (v.dst == 3'd7) ? mem[hl0] : rf[v.dst];
        chk({tag, "_tbl_value"}, 64'(got), 64'(v.exp_val));
      end
    end
  endtask

  initial begin
    vec_t tbl [0:12];
    vec_t rv;
    logic [7:0] mem_before;
    logic [15:0] hl_now;
    bit seen;

    tbl[0]  = '{1'b1, 3'd0, 3'd2, 8'h5A, 0, 1'b0, 2, 8'h5A};  // MVI C
    tbl[1]  = '{1'b0, 3'd2, 3'd1, 8'h00, 0, 1'b0, 3, 8'h5A};  // MOV B,C
    tbl[2]  = '{1'b1, 3'd0, 3'd5, 8'h12, 0, 1'b0, 2, 8'h12};  // MVI H
    tbl[3]  = '{1'b1, 3'd0, 3'd6, 8'h34, 0, 1'b0, 2, 8'h34};  // MVI L
    tbl[4]  = '{1'b0, 3'd7, 3'd3, 8'h00, 2, 1'b0, 5, 8'hA7};  // MOV D,M
    tbl[5]  = '{1'b1, 3'd0, 3'd4, 8'h3C, 0, 1'b0, 2, 8'h3C};  // MVI E
    tbl[6]  = '{1'b0, 3'd4, 3'd7, 8'h00, 0, 1'b0, 3, 8'h3C};  // MOV M,E
    tbl[7]  = '{1'b0, 3'd7, 3'd7, 8'h00, 0, 1'b1, 1, 8'h00};  // MOV M,M
    tbl[8]  = '{1'b0, 3'd1, 3'd0, 8'h00, 0, 1'b1, 1, 8'h00};  // dst 0
    tbl[9]  = '{1'b0, 3'd0, 3'd1, 8'h00, 0, 1'b1, 1, 8'h00};  // src 0
    tbl[10] = '{1'b0, 3'd1, 3'd1, 8'h00, 0, 1'b0, 3, 8'h5A};  // MOV B,B
    tbl[11] = '{1'b1, 3'd0, 3'd7, 8'h77, 3, 1'b0, 5, 8'h77};  // MVI M
    tbl[12] = '{1'b0, 3'd7, 3'd6, 8'h00, 1, 1'b0, 4, 8'h77};  // MOV L,M

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) begin rf[i] = 8'h00; mrf[i] = 8'h00; end
    mem[16'h1234] = 8'hA7;
    reset = 1'b1; start = 1'b0; op_imm_en = 1'b0; op_src = 3'd0; op_dst = 3'd0;
    op_imm = 8'h00; mem_ready = 1'b0; probe_en = 1'b0; probe_val = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, err, rf_en, rf_en_read, rf_addr, mem_rd, mem_wr}, 64'd0);
    probe_en = 1'b1; probe_val = 8'h66; #1;
    chk("reset_bus_released", 64'(data_bus), 64'h66);
    probe_en = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i <= 12; i++) begin
      run_vec(tbl[i], 1'b0, 1'b1, $sformatf("vec%0d", i));
      if (i == 0) begin
        chk("mvi_c_wr_strobe", 64'(tr[1].rf_en_read), 64'd1);
        chk("mvi_c_wr_addr", 64'(tr[1].rf_addr), 64'd2);
        chk("mvi_c_wr_bus", 64'(tr[1].bus), 64'h5A);
        chk("mvi_c_done_at_2", 64'(tr[2].done), 64'd1);
      end else if (i == 1) begin
        chk("mov_bc_rd_en", 64'({tr[1].rf_en, tr[1].rf_addr}), 64'({1'b1, 3'd2}));
        chk("mov_bc_wr", 64'({tr[2].rf_en_read, tr[2].rf_addr, tr[2].bus}),
            64'({1'b1, 3'd1, 8'h5A}));
      end else if (i == 4) begin
        chk("mov_dm_rd_cycles", 64'(n_rd), 64'd3);
        chk("mov_dm_hl_addr", 64'(tr[1].rf_addr), 64'd7);
      end else if (i == 6) begin
        chk("mov_me_wr_cycles", 64'(n_wr), 64'd1);
        chk("mov_me_wr_bus", 64'({tr[2].rf_addr, tr[2].bus}), 64'({3'd7, 8'h3C}));
      end
    end

    // Reset while waiting in MEM_WR aborts with no pulse and no write.
    hl_now = {mrf[5], mrf[6]};
    mem_before = mem[hl_now];
    op_imm_en = 1'b1; op_dst = 3'd7; op_src = 3'd0; op_imm = 8'h99;
    start = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rst_mid_memwr_active", 64'(mem_wr), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_outputs", {busy, done, err, rf_en, rf_en_read, rf_addr, mem_rd, mem_wr}, 64'd0);
    probe_en = 1'b1; probe_val = 8'h66; #1;
    chk("rst_mid_bus_released", 64'(data_bus), 64'h66);
    probe_en = 1'b0;
    reset = 1'b0; mem_ready = 1'b1; seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || err || busy || mem_wr || rf_en_read) seen = 1;
    end
    mem_ready = 1'b0;
    chk("rst_mid_no_activity", 64'(seen), 64'd0);
    chk("rst_mid_mem_kept", 64'(mem[hl_now]), 64'(mem_before));

`ifdef XFER_TIMEOUT_EN
    do_op(1'b0, 3'd7, 3'd1, 8'h00, 1000, 1'b0);
    chk("timeout_err", 64'({op_err, op_done}), 64'({1'b1, 1'b0}));
    chk("timeout_latency", 64'(op_lat), 64'd16);
    chk("timeout_b_kept", 64'(rf[1]), 64'(mrf[1]));
    chk("timeout_busy_after", 64'(op_busy_after), 64'd0);
`endif

    for (int i = 0; i < 250; i++) begin
      rv.imm_en = ($urandom_range(0, 3) == 0);
      rv.src = 3'($urandom);
      rv.dst = 3'($urandom);
      rv.imm = 8'($urandom);
      rv.wt = $urandom_range(0, 4);
      rv.exp_err = 1'b0; rv.exp_lat = 0; rv.exp_val = 8'h00;
      if ($urandom_range(0, 1) == 1) mem[{mrf[5], mrf[6]}] = 8'($urandom);
      run_vec(rv, 1'($urandom), 1'b0, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
